// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module : vga_pkg
// Brief  : 640x480@60 Hz raster constants and pattern index type.
// Rev    : 1.0 - initial release
// ============================================================================
package vga_pkg;

  localparam int c_hpixels      = 800;
  localparam int c_vlines       = 521;
  localparam int c_hsw          = 96;
  localparam int c_vsw          = 2;
  localparam int c_hbp          = 144;
  localparam int c_hfp          = 784;
  localparam int c_vbp          = 31;
  localparam int c_vfp          = 511;
  localparam int c_num_patterns = 4;

  typedef logic [1:0] pattern_t;

endpackage
`default_nettype wire

// File: rtl/vga_pix_tick.sv
`default_nettype none
// ============================================================================
// Module : vga_pix_tick
// Brief  : Divides clk by CLK_DIV into a one-clock pixel-enable strobe.
// Rev    : 1.0 - initial release
// ============================================================================
module vga_pix_tick
  import vga_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic clr,
  output logic pix_en
);

  localparam int c_dw = $clog2(CLK_DIV);

  logic [c_dw-1:0] r_div;
  logic            w_last;

  assign w_last = (r_div == c_dw'(CLK_DIV - 1));
  assign pix_en = w_last;

  always_ff @(posedge clk) begin
    if (clr) begin
      r_div <= '0;
    end else if (w_last) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + c_dw'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/vga_timing_ctrl.sv
`default_nettype none
// ============================================================================
// Module : vga_timing_ctrl
// Brief  : VGA raster timing plus frame-aligned test-pattern scheduler.
// Rev    : 1.0 - initial release
// ============================================================================
module vga_timing_ctrl
  import vga_pkg::*;
#(
  parameter int CLK_DIV        = 4,
  parameter int HPIXELS        = c_hpixels,
  parameter int VLINES         = c_vlines,
  parameter int HSW            = c_hsw,
  parameter int VSW            = c_vsw,
  parameter int HBP            = c_hbp,
  parameter int HFP            = c_hfp,
  parameter int VBP            = c_vbp,
  parameter int VFP            = c_vfp,
  parameter int NUM_PATTERNS   = c_num_patterns,
  parameter int FRAMES_PER_PAT = 60
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       pattern_next,
  input  logic       auto_cycle,
  output logic       pix_en,
  output logic [9:0] hc,
  output logic [9:0] vc,
  output logic       hsync,
  output logic       vsync,
  output logic       vidon,
  output logic       line_start,
  output logic       frame_start,
  output logic [1:0] pattern_sel
);

  localparam int c_fcw = (FRAMES_PER_PAT > 1) ? $clog2(FRAMES_PER_PAT) : 1;

  logic             w_pix_en;
  logic [9:0]       r_hc;
  logic [9:0]       r_vc;
  logic             w_hc_last;
  logic             w_vc_last;
  logic             w_line_start;
  logic             w_frame_start;
  logic [c_fcw-1:0] r_fcnt;
  logic             r_pending;
  pattern_t         r_pat;
  logic             w_auto_due;
  logic             w_advance;

  vga_pix_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_pix_tick (
    .clk    (clk),
    .clr    (clr),
    .pix_en (w_pix_en)
  );

  assign w_hc_last     = (r_hc == 10'(HPIXELS - 1));
  assign w_vc_last     = (r_vc == 10'(VLINES - 1));
  assign w_line_start  = w_pix_en & w_hc_last;
  assign w_frame_start = w_line_start & w_vc_last;

  always_ff @(posedge clk) begin
    if (clr) begin
      r_hc <= '0;
      r_vc <= '0;
    end else if (w_pix_en) begin
      if (w_hc_last) begin
        r_hc <= '0;
        r_vc <= w_vc_last ? 10'd0 : r_vc + 10'd1;
      end else begin
        r_hc <= r_hc + 10'd1;
      end
    end
  end

  // Advance decisions use only the registered pending flag, so a request that
  // arrives on the boundary clock itself is carried into the next frame.
  assign w_auto_due = auto_cycle & (r_fcnt == c_fcw'(FRAMES_PER_PAT - 1));
  assign w_advance  = w_frame_start & (r_pending | w_auto_due);

  always_ff @(posedge clk) begin
    if (clr) begin
      r_fcnt    <= '0;
      r_pending <= 1'b0;
      r_pat     <= '0;
    end else if (w_advance) begin
      r_pat     <= (r_pat == pattern_t'(NUM_PATTERNS - 1)) ? pattern_t'(0)
                                                           : r_pat + pattern_t'(1);
      r_pending <= pattern_next;
      r_fcnt    <= '0;
    end else begin
      r_pending <= r_pending | pattern_next;
      if (!auto_cycle) begin
        r_fcnt <= '0;
      end else if (w_frame_start) begin
        r_fcnt <= r_fcnt + c_fcw'(1);
      end
    end
  end

  assign pix_en      = w_pix_en;
  assign hc          = r_hc;
  assign vc          = r_vc;
  assign hsync       = (r_hc >= 10'(HSW));
  assign vsync       = (r_vc >= 10'(VSW));
  assign vidon       = (r_hc >= 10'(HBP)) && (r_hc < 10'(HFP)) &&
                       (r_vc >= 10'(VBP)) && (r_vc < 10'(VFP));
  assign line_start  = w_line_start;
  assign frame_start = w_frame_start;
  assign pattern_sel = r_pat;

endmodule
`default_nettype wire
